// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type and digit-adjust constants for the binary-to-BCD converter.
package bcd_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 correction applied to one BCD digit before each shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] dig_i,
    output logic [DIGIT_W-1:0] dig_o
);
    assign dig_o = (dig_i >= DIGIT_W'(ADJ_THRESH)) ? dig_i + DIGIT_W'(ADJ_ADD) : dig_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter with sign and leading-zero blanking.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    input  logic                      is_signed,
    output logic                      busy,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] bcd_out,
    output logic                      neg,
    output logic [DIGITS-1:0]         digit_en
);
    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if ((64'd10 ** DIGITS) <= (64'd1 << BIN_W)) begin : g_range_bad
        $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W");
    end

    state_t             state_q;
    logic [BCD_W-1:0]   scratch_q, scratch_d, adj, bcd_q;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q, busy_q, done_q, neg_q;
    logic [DIGITS-1:0]  en_q, en_d;
    logic               seen_nz;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i(scratch_q[i*DIGIT_W +: DIGIT_W]),
            .dig_o(adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    assign scratch_d = {adj[BCD_W-2:0], mag_q[BIN_W-1]};
    assign mag_d     = mag_q << 1;

    // A digit stays lit once any more-significant digit is nonzero; ones digit always lit.
    always_comb begin
        en_d    = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (|scratch_d[i*DIGIT_W +: DIGIT_W]);
            en_d[i] = seen_nz;
        end
        en_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            en_q      <= DIGITS'(1);
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    mag_q     <= (is_signed && bin_in[BIN_W-1]) ? -bin_in : bin_in;
                    sign_q    <= is_signed && bin_in[BIN_W-1];
                    scratch_q <= '0;
                    cnt_q     <= CNT_W'(BIN_W - 1);
                    busy_q    <= 1'b1;
                    state_q   <= SHIFT;
                end
            end else begin
                scratch_q <= scratch_d;
                mag_q     <= mag_d;
                cnt_q     <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    bcd_q   <= scratch_d;
                    neg_q   <= sign_q;
                    en_q    <= en_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign neg      = neg_q;
    assign digit_en = en_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table-driven, hand-sequenced and randomized checks of bin2bcd_seq against a decimal model.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        is_signed = 1'b0;
    logic        busy, done, neg;
    logic [19:0] bcd_out;
    logic [4:0]  digit_en;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .bin_in(bin_in), .is_signed(is_signed),
        .busy(busy), .done(done), .bcd_out(bcd_out), .neg(neg), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic        sgn;
        logic [19:0] bcd;
        logic [4:0]  en;
        logic        ng;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: plain integer arithmetic on the interpreted value.
    task automatic model(input logic [15:0] b, input logic s,
                         output logic [19:0] bcd, output logic [4:0] en, output logic ng);
        int v, top, d;
        v   = s ? int'($signed(b)) : int'(b);
        ng  = v < 0;
        v   = ng ? -v : v;
        top = 0;
        bcd = '0;
        for (int i = 0; i < 5; i++) begin
            d = v % 10;
            bcd[i*4 +: 4] = 4'(d);
            if (d != 0) top = i;
            v = v / 10;
        end
        for (int i = 0; i < 5; i++) en[i] = (i <= top);
    endtask

    task automatic convert(input logic [15:0] b, input logic s, output int lat);
        logic [19:0] held;
        @(negedge clk);
        bin_in = b; is_signed = s; start = 1'b1;
        held = bcd_out;
        @(posedge clk); #1;
        start = 1'b0;
        bin_in = ~b; is_signed = ~s;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 8) chk("held_during_shift", 32'(bcd_out), 32'(held));
        end
    endtask

    vec_t vt[$];
    logic [19:0] e_bcd;
    logic [4:0]  e_en;
    logic        e_ng;
    int          lat, dcount, d_edge[$], idle_cnt;
    logic [19:0] d_bcd[$];
    logic [4:0]  d_en[$];

    initial begin
        vt.push_back('{16'h0000, 1'b0, 20'h00000, 5'b00001, 1'b0});
        vt.push_back('{16'hFFFF, 1'b0, 20'h65535, 5'b11111, 1'b0});
        vt.push_back('{16'hFFFB, 1'b1, 20'h00005, 5'b00001, 1'b1});
        vt.push_back('{16'hFFFB, 1'b0, 20'h65531, 5'b11111, 1'b0});
        vt.push_back('{16'h8000, 1'b1, 20'h32768, 5'b11111, 1'b1});
        vt.push_back('{16'h8000, 1'b0, 20'h32768, 5'b11111, 1'b0});
        vt.push_back('{16'hFFFF, 1'b1, 20'h00001, 5'b00001, 1'b1});
        vt.push_back('{16'h7FFF, 1'b1, 20'h32767, 5'b11111, 1'b0});
        vt.push_back('{16'd1000, 1'b0, 20'h01000, 5'b01111, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_neg", 32'(neg), 0);
        chk("rst_en", 32'(digit_en), 1);
        @(negedge clk); rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_no_done", 32'(done), 0);
        end

        foreach (vt[i]) begin
            convert(vt[i].bin, vt[i].sgn, lat);
            chk("vec_latency", 32'(lat), 16);
            chk("vec_bcd", 32'(bcd_out), 32'(vt[i].bcd));
            chk("vec_en", 32'(digit_en), 32'(vt[i].en));
            chk("vec_neg", 32'(neg), 32'(vt[i].ng));
            chk("vec_busy_at_done", 32'(busy), 0);
            @(posedge clk); #1;
            chk("vec_done_pulse", 32'(done), 0);
            chk("vec_hold_bcd", 32'(bcd_out), 32'(vt[i].bcd));
        end

        // Start held high: 255 then 1234; 9999 sits on bin_in only while busy.
        @(negedge clk);
        bin_in = 16'd255; is_signed = 1'b0; start = 1'b1;
        idle_cnt = 0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #1;
            if (e == 1 || e == 18) bin_in = 16'd9999;
            if (e == 10) bin_in = 16'd1234;
            if (e == 30) start = 1'b0;
            if (e < 34 && !busy) idle_cnt++;
            if (done) begin
                d_edge.push_back(e);
                d_bcd.push_back(bcd_out);
                d_en.push_back(digit_en);
            end
        end
        chk("b2b_done_count", 32'(d_edge.size()), 2);
        if (d_edge.size() == 2) begin
            chk("b2b_done1_edge", 32'(d_edge[0]), 17);
            chk("b2b_done2_edge", 32'(d_edge[1]), 34);
            chk("b2b_bcd1", 32'(d_bcd[0]), 32'h00255);
            chk("b2b_en1", 32'(d_en[0]), 32'b00111);
            chk("b2b_bcd2", 32'(d_bcd[1]), 32'h01234);
            chk("b2b_en2", 32'(d_en[1]), 32'b01111);
        end
        chk("b2b_idle_cycles", 32'(idle_cnt), 1);

        // Reset mid-conversion aborts with no done; restart completes normally.
        @(negedge clk);
        bin_in = 16'd999; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bcd", 32'(bcd_out), 0);
        chk("abort_en", 32'(digit_en), 1);
        chk("abort_neg", 32'(neg), 0);
        @(negedge clk); rstn = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 0);
        convert(16'd999, 1'b0, lat);
        chk("restart_latency", 32'(lat), 16);
        chk("restart_bcd", 32'(bcd_out), 32'h00999);
        chk("restart_en", 32'(digit_en), 32'b00111);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] b;
            logic        s;
            b = 16'($urandom);
            if (i % 4 == 0) b = b >> ($urandom_range(15, 4));
            s = 1'($urandom);
            model(b, s, e_bcd, e_en, e_ng);
            convert(b, s, lat);
            chk("rnd_latency", 32'(lat), 16);
            chk("rnd_bcd", 32'(bcd_out), 32'(e_bcd));
            chk("rnd_en", 32'(digit_en), 32'(e_en));
            chk("rnd_neg", 32'(neg), 32'(e_ng));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
